// File: rtl/log_ctrl_pkg.sv
// Shared state encoding and default sizing for the sample-logger readout sequencer.
package log_ctrl_pkg;

  localparam int BRAM_ADDR_WIDTH_DEF = 15;
  localparam int BRAM_DATA_WIDTH_DEF = 16;
  localparam int READ_LAT_DEF        = 2;
  localparam int READ_LAT_MAX        = 7;
  localparam int TIMEOUT_CYC_DEF     = 2**20;
  localparam int LAT_CNT_W           = 3;
  localparam int TMO_CNT_W           = 21;

  localparam logic [2:0] ENC_IDLE      = 3'd0;
  localparam logic [2:0] ENC_ARM       = 3'd1;
  localparam logic [2:0] ENC_WAIT_FULL = 3'd2;
  localparam logic [2:0] ENC_ENTER_RD  = 3'd3;
  localparam logic [2:0] ENC_WAIT_RD   = 3'd4;
  localparam logic [2:0] ENC_PRESENT   = 3'd5;
  localparam logic [2:0] ENC_DONE      = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE      = ENC_IDLE,
    ST_ARM       = ENC_ARM,
    ST_WAIT_FULL = ENC_WAIT_FULL,
    ST_ENTER_RD  = ENC_ENTER_RD,
    ST_WAIT_RD   = ENC_WAIT_RD,
    ST_PRESENT   = ENC_PRESENT,
    ST_DONE      = ENC_DONE
  } state_t;

endpackage

// File: rtl/log_rd_pacer.sv
// Read-latency pacer: counts out the logger read latency, captures the word and
// holds it with valid until the consumer accepts it.
module log_rd_pacer
  import log_ctrl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int READ_LAT = READ_LAT_DEF
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_count,
  input  logic              i_accept,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_fire,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid
);

  logic [LAT_CNT_W-1:0] lat_cnt;

  // Counting READ_LAT down to zero spans READ_LAT+1 cycles, so the capture lands
  // on the first cycle the logger output reflects the new address.
  assign o_fire = i_count && (lat_cnt == '0) && !i_clear;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lat_cnt <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_load)
        lat_cnt <= LAT_CNT_W'(READ_LAT);
      else if (i_count && (lat_cnt != '0))
        lat_cnt <= lat_cnt - 1'b1;

      if (o_fire)
        o_data <= i_data;

      if (i_clear || i_accept)
        o_valid <= 1'b0;
      else if (o_fire)
        o_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/log_readout_ctrl.sv
// Capture/readout sequencer for the two-bank sample logger.
// Define LOG_RO_TIMEOUT_EN to add the WAIT_FULL watchdog and sticky o_error.
//
// state     | meaning
// IDLE      | waiting for i_start
// ARM       | o_run_log pulse, logger starts capturing
// WAIT_FULL | waiting for i_mem_full (first cycle ignored)
// ENTER_RD  | o_read_log pulse, address 0, latency counter loaded
// WAIT_RD   | counting out read latency, capture word at zero
// PRESENT   | o_valid held until i_ready
// DONE      | one-cycle o_done
module log_readout_ctrl
  import log_ctrl_pkg::*;
#(
  parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter int BRAM_DATA_WIDTH = BRAM_DATA_WIDTH_DEF,
  parameter int READ_LAT        = READ_LAT_DEF,
  parameter int TIMEOUT_CYC     = TIMEOUT_CYC_DEF
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [BRAM_ADDR_WIDTH-1:0]   i_read_len,
  input  logic                         i_mem_full,
  input  logic [2*BRAM_DATA_WIDTH-1:0] i_data_log,
  output logic                         o_run_log,
  output logic                         o_read_log,
  output logic [BRAM_ADDR_WIDTH-1:0]   o_addr_log,
  output logic [2*BRAM_DATA_WIDTH-1:0] o_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_error
);

  localparam int DW = 2*BRAM_DATA_WIDTH;
  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(TIMEOUT_CYC - 1);

  state_t                     state;
  logic [BRAM_ADDR_WIDTH-1:0] len_q;
  logic                       first_wait;
  logic                       full_seen;
  logic                       fire;
  logic                       handshake;
  logic                       last_word;
  logic                       pacer_load;
  logic                       start_ok;
  logic                       tmo_hit;

  assign start_ok   = i_start && !i_abort && ((state == ST_IDLE) || (state == ST_DONE));
  assign full_seen  = (state == ST_WAIT_FULL) && !first_wait && i_mem_full;
  assign handshake  = (state == ST_PRESENT) && o_valid && i_ready && !i_abort;
  // Termination is tested before the increment, so an all-ones length never wraps.
  assign last_word  = (o_addr_log == len_q);
  assign pacer_load = !i_abort && ((state == ST_ENTER_RD) || (handshake && !last_word));

  assign o_busy = (state != ST_IDLE) && (state != ST_DONE);
  assign o_done = (state == ST_DONE);

  log_rd_pacer #(
    .DATA_W  (DW),
    .READ_LAT(READ_LAT)
  ) u_pacer (
    .clk     (clk),
    .i_rst_n (i_rst_n),
    .i_load  (pacer_load),
    .i_count (state == ST_WAIT_RD),
    .i_accept(handshake),
    .i_clear (i_abort),
    .i_data  (i_data_log),
    .o_fire  (fire),
    .o_data  (o_data),
    .o_valid (o_valid)
  );

`ifdef LOG_RO_TIMEOUT_EN
  logic [TMO_CNT_W-1:0] tmo_cnt;
  logic                 error_q;

  assign tmo_hit = (state == ST_WAIT_FULL) && !full_seen && (tmo_cnt == TMO_LAST);
  assign o_error = error_q;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_cnt <= '0;
      error_q <= 1'b0;
    end else begin
      tmo_cnt <= (state == ST_WAIT_FULL) ? tmo_cnt + 1'b1 : '0;
      if (start_ok)
        error_q <= 1'b0;
      else if (tmo_hit && !i_abort)
        error_q <= 1'b1;
    end
  end
`else
  // Timeout length only matters when the watchdog is built in.
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TMO_LAST;
  assign tmo_hit = 1'b0;
  assign o_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      o_addr_log <= '0;
      o_run_log  <= 1'b0;
      o_read_log <= 1'b0;
      first_wait <= 1'b0;
    end else begin
      o_run_log  <= 1'b0;
      o_read_log <= 1'b0;
      if (i_abort) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE, ST_DONE: begin
            if (i_start) begin
              len_q     <= i_read_len;
              o_run_log <= 1'b1;
              state     <= ST_ARM;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_ARM: begin
            first_wait <= 1'b1;
            state      <= ST_WAIT_FULL;
          end
          ST_WAIT_FULL: begin
            first_wait <= 1'b0;
            if (full_seen) begin
              o_read_log <= 1'b1;
              o_addr_log <= '0;
              state      <= ST_ENTER_RD;
            end else if (tmo_hit) begin
              state <= ST_IDLE;
            end
          end
          ST_ENTER_RD: state <= ST_WAIT_RD;
          ST_WAIT_RD: begin
            if (fire)
              state <= ST_PRESENT;
          end
          ST_PRESENT: begin
            if (handshake) begin
              if (last_word) begin
                state <= ST_DONE;
              end else begin
                o_addr_log <= o_addr_log + 1'b1;
                state      <= ST_WAIT_RD;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
